// File: rtl/bus_timer_array.sv
// rtl/bus_timer_array.sv - multi-channel bus-mapped countdown timer; TIMER_SNAPSHOT_EN adds the count high-byte snapshot at +3
module bus_timer_array #(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NUM_CH    = 2,
  parameter int         CNT_W     = 16,
  parameter int         PRESCALE  = 99999
) (
  input  logic       CLK,
  input  logic       RESETN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int PW = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);

  logic [PW-1:0]     presc;
  logic [7:0]        tick_cnt;
  logic [7:0]        off;
  logic              hit;
  logic              wr;
  logic              rd;
  logic              wr_pend;
  logic              wr_clr;
  logic              tick;
  logic              tick_eff;
  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_ctrl;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] periodic;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] expire;
  logic [NUM_CH-1:0] irq_cand;
  logic [NUM_CH-1:0] ack_mask;
  logic [CNT_W-1:0]  reload [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [7:0]        rd_next;
  logic [7:0]        rd_data;
  logic              rd_valid;

  // Window decode: offset relative to the base, 16-byte window
  assign off      = BUS_ADDR - BASE_ADDR;
  assign hit      = (off[7:4] == 4'h0);
  assign wr       = BUS_WE & hit;
  assign rd       = ~BUS_WE & hit;
  assign wr_pend  = wr & (off[3:0] == 4'd1);
  assign wr_clr   = wr & (off[3:0] == 4'd2);
  assign tick     = (presc == PW'(PRESCALE));
  // A prescaler clear in the same cycle swallows the tick everywhere
  assign tick_eff = tick & ~wr_clr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    assign ch_hit[g]  = hit & (off[3:2] == 2'(g + 1));
    assign wr_ctrl[g] = wr & ch_hit[g] & (off[1:0] == 2'd0);
  end

  // Expiry detect; a ctrl write in the same cycle re-arms instead
  always_comb begin
    expire = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      expire[n] = tick_eff & en[n] & ~wr_ctrl[n] & (count[n] == CNT_W'(1));
    end
  end

  // Shared prescaler and free-running tick counter
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      presc    <= '0;
      tick_cnt <= 8'h00;
    end else if (wr_clr) begin
      presc    <= '0;
      tick_cnt <= 8'h00;
    end else if (tick) begin
      presc    <= '0;
      tick_cnt <= tick_cnt + 8'd1;
    end else begin
      presc    <= presc + PW'(1);
    end
  end

  // Per-channel ctrl, reload and countdown
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      en       <= '0;
      periodic <= '0;
      irq_en   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        reload[n] <= '0;
        count[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr && ch_hit[n] && off[1:0] == 2'd1) reload[n][7:0] <= BUS_DATA;
        if (wr && ch_hit[n] && off[1:0] == 2'd2) reload[n][CNT_W-1:8] <= BUS_DATA[CNT_W-9:0];
        if (wr_ctrl[n]) begin
          en[n]       <= BUS_DATA[0];
          periodic[n] <= BUS_DATA[1];
          irq_en[n]   <= BUS_DATA[2];
          if (BUS_DATA[0]) count[n] <= reload[n];
        end else if (tick_eff && en[n]) begin
          if (expire[n]) begin
            if (periodic[n]) begin
              count[n] <= reload[n];
            end else begin
              count[n] <= '0;
              en[n]    <= 1'b0;
            end
          end else if (count[n] != '0) begin
            count[n] <= count[n] - CNT_W'(1);
          end
        end
      end
    end
  end

  // Pending next state: W1C and ACK clear first, expiry sets last so it wins
  always_comb begin
    irq_cand = pending & irq_en;
    ack_mask = irq_cand & (~irq_cand + NUM_CH'(1));
    pend_nxt = pending;
    if (wr_pend) pend_nxt = pend_nxt & ~BUS_DATA[NUM_CH-1:0];
    if (BUS_INTERRUPT_ACK) pend_nxt = pend_nxt & ~ack_mask;
    pend_nxt = pend_nxt | expire;
  end

  // Pending register and registered interrupt request
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pending             <= '0;
      BUS_INTERRUPT_RAISE <= 1'b0;
    end else begin
      pending             <= pend_nxt;
      BUS_INTERRUPT_RAISE <= |(pending & irq_en);
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [7:0] snap;

  // Count-low read latches the matching high byte for a coherent 16-bit read
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      snap <= 8'h00;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (rd && ch_hit[n] && off[1:0] == 2'd3) snap <= 8'(count[n][CNT_W-1:8]);
      end
    end
  end
`endif

  // Read data mux
  always_comb begin
    rd_next = 8'h00;
    case (off[3:0])
      4'd0:    rd_next = tick_cnt;
      4'd1:    rd_next = 8'(pending);
`ifdef TIMER_SNAPSHOT_EN
      4'd3:    rd_next = snap;
`endif
      default: rd_next = 8'h00;
    endcase
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_hit[n]) begin
        case (off[1:0])
          2'd0:    rd_next = {5'b00000, irq_en[n], periodic[n], en[n]};
          2'd1:    rd_next = reload[n][7:0];
          2'd2:    rd_next = 8'(reload[n][CNT_W-1:8]);
          default: rd_next = count[n][7:0];
        endcase
      end
    end
  end

  // Read capture: data goes out the cycle after the address is sampled
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd;
      if (rd) rd_data <= rd_next;
    end
  end

  assign BUS_DATA = (rd_valid && !BUS_WE) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_bus_timer_array.sv
// tb/tb_bus_timer_array.sv - scoreboard bench for bus_timer_array (PRESCALE=3, two channels)
module tb_bus_timer_array;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [7:0] BUS_ADDR;
  logic       BUS_WE;
  logic       BUS_INTERRUPT_ACK;
  logic       tb_oe;
  logic [7:0] tb_d;
  wire  [7:0] BUS_DATA;
  wire        BUS_INTERRUPT_RAISE;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t_arm;
  int         seen;
  logic [7:0] exp_q[$];

  localparam logic [7:0] B = 8'hF0;
  localparam logic [7:0] IDLE_BUS = 8'hFF;

  bus_timer_array #(
    .BASE_ADDR(8'hF0),
    .NUM_CH(2),
    .CNT_W(16),
    .PRESCALE(3)
  ) dut (
    .CLK(CLK),
    .RESETN(RESETN),
    .BUS_DATA(BUS_DATA),
    .BUS_ADDR(BUS_ADDR),
    .BUS_WE(BUS_WE),
    .BUS_INTERRUPT_RAISE(BUS_INTERRUPT_RAISE),
    .BUS_INTERRUPT_ACK(BUS_INTERRUPT_ACK)
  );

  assign BUS_DATA = tb_oe ? tb_d : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (BUS_DATA[i]);
  end

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a;
    tb_d     = d;
    tb_oe    = 1'b1;
    BUS_WE   = 1'b1;
    @(negedge CLK);
    BUS_WE   = 1'b0;
    tb_oe    = 1'b0;
    BUS_ADDR = 8'h00;
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] e, input string tag);
    BUS_ADDR = a;
    BUS_WE   = 1'b0;
    exp_q.push_back(e);
    @(negedge CLK);
    BUS_ADDR = 8'h00;
    check_val(tag, BUS_DATA, exp_q.pop_front());
  endtask

  task automatic ack_pulse();
    BUS_INTERRUPT_ACK = 1'b1;
    @(negedge CLK);
    BUS_INTERRUPT_ACK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic wait_raise(input logic val, input int bound, input string tag);
    int k = 0;
    while (BUS_INTERRUPT_RAISE !== val && k < bound) begin
      @(negedge CLK);
      k++;
    end
    check_val(tag, BUS_INTERRUPT_RAISE, val);
  endtask

  initial begin
    RESETN = 1'b0;
    BUS_ADDR = 8'h00;
    BUS_WE = 1'b0;
    BUS_INTERRUPT_ACK = 1'b0;
    tb_oe = 1'b0;
    tb_d = 8'h00;
    @(negedge CLK);
    @(negedge CLK);
    check_val("rst_raise", BUS_INTERRUPT_RAISE, 1'b0);
    check_val("rst_bus", BUS_DATA, IDLE_BUS);
    RESETN = 1'b1;
    bus_read(B + 8'd1, 8'h00, "rst_pending");
    bus_read(B + 8'd4, 8'h00, "rst_ctrl0");
    bus_read(B + 8'd5, 8'h00, "rst_reload0");
    bus_read(B + 8'd3, 8'h00, "rst_snap");

    // periodic ch0, reload 5: expiry every 20 cycles
    bus_write(B + 8'd5, 8'd5);
    bus_write(B + 8'd6, 8'd0);
    bus_write(B + 8'd2, 8'h00);
    bus_write(B + 8'd4, 8'h07);
    t_arm = cyc;
    wait_raise(1'b1, 40, "p1_raise");
    check_val("p1_latency", cyc - t_arm, 20);
    bus_read(B + 8'd0, 8'd5, "p1_tickcnt");
    bus_read(B + 8'd1, 8'h01, "p1_pending");
    BUS_INTERRUPT_ACK = 1'b1;
    @(negedge CLK);
    BUS_INTERRUPT_ACK = 1'b0;
    check_val("p1_ack_hold", BUS_INTERRUPT_RAISE, 1'b1);
    @(negedge CLK);
    check_val("p1_ack_fall", BUS_INTERRUPT_RAISE, 1'b0);
    wait_raise(1'b1, 40, "p2_raise");
    check_val("p2_latency", cyc - t_arm, 40);
    ack_pulse();
    bus_write(B + 8'd4, 8'h00);

    // one-shot ch1, reload 2
    bus_write(B + 8'd9, 8'd2);
    bus_write(B + 8'd10, 8'd0);
    bus_write(B + 8'd8, 8'h05);
    wait_raise(1'b1, 20, "os_raise");
    bus_read(B + 8'd8, 8'h04, "os_ctrl");
    bus_read(B + 8'd11, 8'h00, "os_count");
    bus_read(B + 8'd1, 8'h02, "os_pending");
    ack_pulse();
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      if (BUS_INTERRUPT_RAISE) seen++;
    end
    check_val("os_quiet", seen, 0);
    bus_read(B + 8'd1, 8'h00, "os_pending_after");

    // both channels expire on the same tick
    bus_write(B + 8'd5, 8'd3);
    bus_write(B + 8'd9, 8'd3);
    bus_write(B + 8'd2, 8'h00);
    bus_write(B + 8'd4, 8'h05);
    bus_write(B + 8'd8, 8'h05);
    wait_raise(1'b1, 30, "dual_raise");
    bus_read(B + 8'd1, 8'h03, "dual_pending");
    ack_pulse();
    check_val("dual_ack1_hold", BUS_INTERRUPT_RAISE, 1'b1);
    bus_read(B + 8'd1, 8'h02, "dual_pending1");
    ack_pulse();
    check_val("dual_ack2_fall", BUS_INTERRUPT_RAISE, 1'b0);
    bus_read(B + 8'd1, 8'h00, "dual_pending2");

    // W1C in the same cycle as expiry loses
    bus_write(B + 8'd5, 8'd2);
    bus_write(B + 8'd6, 8'd0);
    bus_write(B + 8'd2, 8'h00);
    bus_write(B + 8'd4, 8'h07);
    t_arm = cyc;
    while (cyc < t_arm + 6) @(negedge CLK);
    bus_write(B + 8'd1, 8'h01);
    bus_write(B + 8'd4, 8'h00);
    bus_read(B + 8'd1, 8'h01, "w1c_race");
    bus_write(B + 8'd1, 8'hFF);
    bus_read(B + 8'd1, 8'h00, "w1c_clear");

    // coherent count read
    bus_write(B + 8'd5, 8'h34);
    bus_write(B + 8'd6, 8'h12);
    bus_write(B + 8'd2, 8'h00);
    bus_write(B + 8'd4, 8'h01);
    bus_read(B + 8'd7, 8'h34, "snap_lo");
`ifdef TIMER_SNAPSHOT_EN
    bus_read(B + 8'd3, 8'h12, "snap_hi");
`else
    bus_read(B + 8'd3, 8'h00, "snap_hi");
`endif

    // no drive while BUS_WE is high
    BUS_ADDR = B + 8'd4;
    BUS_WE = 1'b0;
    @(negedge CLK);
    check_val("drive_on", BUS_DATA, 8'h01);
    BUS_ADDR = 8'h00;
    BUS_WE = 1'b1;
    #1;
    check_val("drive_we_gate", BUS_DATA, IDLE_BUS);
    @(negedge CLK);
    BUS_WE = 1'b0;
    bus_write(B + 8'd4, 8'h00);

    // asynchronous reset mid-count with the interrupt raised
    bus_write(B + 8'd5, 8'd1);
    bus_write(B + 8'd6, 8'd0);
    bus_write(B + 8'd4, 8'h07);
    wait_raise(1'b1, 20, "ar_raise");
    BUS_ADDR = B + 8'd4;
    BUS_WE = 1'b0;
    @(posedge CLK);
    #2;
    check_val("ar_pre_drive", BUS_DATA, 8'h07);
    RESETN = 1'b0;
    #1;
    check_val("ar_raise_low", BUS_INTERRUPT_RAISE, 1'b0);
    check_val("ar_bus_rel", BUS_DATA, IDLE_BUS);
    @(negedge CLK);
    @(negedge CLK);
    BUS_ADDR = 8'h00;
    RESETN = 1'b1;
    bus_read(B + 8'd0, 8'h00, "ar_tickcnt");
    bus_read(B + 8'd1, 8'h00, "ar_pending");
    bus_read(B + 8'd4, 8'h00, "ar_ctrl0");
    bus_read(B + 8'd5, 8'h00, "ar_reload0");
    bus_read(B + 8'd7, 8'h00, "ar_count0");
    bus_read(B + 8'd3, 8'h00, "ar_snap");
    check_val("ar_raise_after", BUS_INTERRUPT_RAISE, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_timer_array.md
# bus_timer_array

Multi-channel, bus-mapped countdown timer: a shared prescaler produces a tick, and each of NUM_CH independent channels counts down from a programmable reload value in periodic or one-shot mode. Expiries set per-channel pending bits, which merge into a single interrupt request. The block sits on the 8-bit processor bus alongside the other memory-mapped peripherals. It replaces the single fixed-rate timer with a wider, multi-channel, mode-selectable one.

## Interface
- BASE_ADDR, 8'hF0, base of a 16-byte register window
- NUM_CH, 2, channel count, legal 1..3
- CNT_W, 16, channel counter/reload width, legal 9..16
- PRESCALE, 99999, tick period minus one in CLK cycles (1 ms at 100 MHz)
- CLK  in  1  system clock, all state on rising edge
- RESETN  in  1  asynchronous, active-low reset
- BUS_DATA  inout  8  bidirectional data, tristated when not driving
- BUS_ADDR  in  8  address
- BUS_WE  in  1  write strobe, write takes effect on the sampling edge
- BUS_INTERRUPT_RAISE  out  1  interrupt request, level
- BUS_INTERRUPT_ACK  in  1  interrupt acknowledge, one-cycle pulse

## Operation
- Register map, offsets from BASE_ADDR:
  - +0: R tick counter [7:0].
  - +1: R pending[NUM_CH-1:0]; W1C.
  - +2: W any value clears the prescaler and tick counter.
  - +3: R snapshot high byte (see Configuration).
  - +4+4n, channel n ctrl, RW: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN, other bits read 0.
  - +5+4n: RW reload[7:0].
  - +6+4n: RW reload[CNT_W-1:8], unused bits read 0.
  - +7+4n: R count[7:0].
  - Offsets outside this map read 0 and ignore writes.
- Prescaler: counts 0..PRESCALE and wraps. tick is a one-cycle pulse when the prescaler equals PRESCALE. The 8-bit tick counter increments on tick and wraps 255->0.
- Channel arming: a write to ctrl with EN=1 loads count <= reload in the same edge. A write with EN=0 stops the channel and keeps count.
- Counting: on tick with EN=1, count decrements.
  - If count==1 at tick, the channel expires: pending[n] sets.
  - PERIODIC=1: count <= reload.
  - PERIODIC=0: count <= 0 and EN clears.
- reload==0: arming loads 0 and the channel never expires.
- Interrupt: BUS_INTERRUPT_RAISE = OR over n of (pending[n] & IRQ_EN[n]), registered.
- ACK clears the lowest-index pending bit whose IRQ_EN is set.
- Simultaneous events:
  - Expiry beats a W1C or ACK clear of the same bit in the same cycle; the bit stays set.
  - A ctrl write beats a tick in the same cycle; the channel loads reload and does not decrement.
  - A write to +2 beats a tick; the tick is discarded.
- Reset (asynchronous, any time): all counters, ctrl, reload, pending and the snapshot go to 0. BUS_INTERRUPT_RAISE=0. BUS_DATA goes to Z.

## Timing
- Write: takes effect on the CLK edge where BUS_WE=1 and the address matches.
- Read:
  - Cycle 0: the address is sampled with BUS_WE=0 and read data is captured into a register.
  - Cycle 1: BUS_DATA is driven with the captured data.
  - The drive lasts exactly one cycle per sampled read cycle, and BUS_DATA is never driven while BUS_WE=1.
- Expiry to IRQ: pending sets on the edge after tick. BUS_INTERRUPT_RAISE rises one cycle later.
- ACK to deassert: the pending bit clears on the ACK edge. RAISE falls the next cycle if nothing else is pending.
- Arm to first expiry: reload ticks, so the first expiry is reload×(PRESCALE+1) cycles minus the prescaler phase at arming.

## Configuration
- TIMER_SNAPSHOT_EN defined: a read of any channel's +7+4n captures that channel's count[CNT_W-1:8] into the snapshot register on the same edge as the low byte. A following read of +3 returns it, giving a coherent 16-bit count. The snapshot holds until the next count-low read.
- Not defined: there is no snapshot register, +3 reads 0, and only count[7:0] is observable.

## Test plan
- PRESCALE=3, NUM_CH=2, ch0 reload=5, PERIODIC=1, IRQ_EN=1, EN=1 -> pending[0] sets every 20 cycles; RAISE rises 1 cycle after each pending set; ACK pulse -> RAISE low next cycle.
- ch1 one-shot, reload=2 -> one expiry after 2 ticks; ctrl reads back EN=0, count=0; no further pending over 50 ticks.
- ch0 and ch1 expire on the same tick, both IRQ_EN=1 -> pending=2'b11; first ACK clears bit0 with RAISE still 1; second ACK clears bit1 and RAISE falls.
- W1C of pending[0] in the same cycle ch0 expires -> pending[0] remains 1.
- With TIMER_SNAPSHOT_EN, reload=16'h1234 armed, read +7 then +3 before a tick -> 8'h34 then 8'h12; without the macro, +3 -> 8'h00.
- RESETN pulled low mid-count with RAISE=1 -> RAISE=0, all registers read 0, BUS_DATA=Z within the reset assertion, with no clock edge needed.
